// File: rtl/button_pulse_gen_pkg.sv
// rtl/button_pulse_gen_pkg.sv - shared state encoding for push-button conditioning blocks
package button_pulse_gen_pkg;

    // Encoding is fixed so later input-conditioning blocks decode states identically.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

endpackage

// File: rtl/button_pulse_gen_sync_2ff.sv
// rtl/button_pulse_gen_sync_2ff.sv - two-flop synchronizer for one asynchronous bit
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_pulse_gen.sv
// rtl/button_pulse_gen.sv - debounced single-pulse generator with optional hold-to-repeat
module button_pulse_gen
    import button_pulse_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 4,
    parameter int CNT_W           = 8
) (
    input  logic input_CLK,
    input  logic input_RST,
    input  logic input_BTN,
    output logic output_PULSE,
    output logic output_LEVEL
);

    localparam bit             REPEAT_EN = (REPEAT_DELAY > 0);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

    logic             btn_s;
    btn_state_t       state;
    logic [CNT_W-1:0] timer;
    logic             pulse;
    logic             level;
    logic             repeat_first;

    sync_2ff u_sync (
        .clk (input_CLK),
        .rst (input_RST),
        .d   (input_BTN),
        .q   (btn_s)
    );

    // Debounce/repeat FSM; the timer is compared before incrementing and cleared on every
    // transition so it never wraps. The repeat timer idles during a pulse cycle, which keeps
    // repeat pulses from ever landing on adjacent cycles.
    always_ff @(posedge input_CLK) begin
        if (input_RST) begin
            state        <= IDLE;
            timer        <= '0;
            pulse        <= 1'b0;
            level        <= 1'b0;
            repeat_first <= 1'b1;
        end else begin
            pulse <= 1'b0;
            case (state)
                IDLE: begin
                    level <= 1'b0;
                    timer <= '0;
                    if (btn_s) begin
                        state <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (timer == DB_LAST) begin
                        state        <= HELD;
                        timer        <= '0;
                        pulse        <= 1'b1;
                        level        <= 1'b1;
                        repeat_first <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state <= RELEASE_WAIT;
                        timer <= '0;
                    end else if (REPEAT_EN && !pulse) begin
                        if (timer == (repeat_first ? RD_LAST : RP_LAST)) begin
                            pulse        <= 1'b1;
                            timer        <= '0;
                            repeat_first <= 1'b0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_s) begin
                        state        <= HELD;
                        timer        <= '0;
                        repeat_first <= 1'b1;
                    end else if (timer == DB_LAST) begin
                        state <= IDLE;
                        timer <= '0;
                        level <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    assign output_PULSE = pulse;
    assign output_LEVEL = level;

endmodule
